instruction_decoder_rv32i: RTL and testbench

INSTRUCTION_DECODER_RV32I -- requirements
Module: instruction_decoder

---
 rtl/instruction_decoder_rv32i_pkg.sv | 77 +++++++
 rtl/instruction_decoder_rv32i_imm_gen.sv | 21 ++
 rtl/instruction_decoder_rv32i.sv | 131 +++++++++++++
 tb/tb_instruction_decoder_rv32i.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_decoder_rv32i_pkg.sv
// Shared RV32I decode constants: format codes, ALU op codes, opcodes and field helpers.
package instruction_decoder_rv32i_pkg;

  localparam logic [2:0] FT_R    = 3'd0;
  localparam logic [2:0] FT_I    = 3'd1;
  localparam logic [2:0] FT_S    = 3'd2;
  localparam logic [2:0] FT_B    = 3'd3;
  localparam logic [2:0] FT_U    = 3'd4;
  localparam logic [2:0] FT_J    = 3'd5;
  localparam logic [2:0] FT_NONE = 3'd7;

  localparam logic [4:0] ALU_ADD   = 5'b00000;
  localparam logic [4:0] ALU_SUB   = 5'b00001;
  localparam logic [4:0] ALU_AND   = 5'b00010;
  localparam logic [4:0] ALU_OR    = 5'b00011;
  localparam logic [4:0] ALU_XOR   = 5'b00100;
  localparam logic [4:0] ALU_SLT   = 5'b00101;
  localparam logic [4:0] ALU_SLTU  = 5'b00110;
  localparam logic [4:0] ALU_PASSB = 5'b00111;
  localparam logic [4:0] ALU_EQ    = 5'b01000;
  localparam logic [4:0] ALU_NE    = 5'b01001;
  localparam logic [4:0] ALU_LT    = 5'b01010;
  localparam logic [4:0] ALU_GE    = 5'b01011;
  localparam logic [4:0] ALU_LTU   = 5'b01100;
  localparam logic [4:0] ALU_GEU   = 5'b01101;
  localparam logic [4:0] ALU_SLL   = 5'b10000;
  localparam logic [4:0] ALU_SRL   = 5'b10001;
  localparam logic [4:0] ALU_SRA   = 5'b10010;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;

  localparam logic [1:0] MEM_NONE = 2'b00;
  localparam logic [1:0] MEM_BYTE = 2'b01;
  localparam logic [1:0] MEM_HALF = 2'b10;
  localparam logic [1:0] MEM_WORD = 2'b11;

  // IR field positions
  localparam int unsigned IR_OPCODE_MSB = 6;
  localparam int unsigned IR_RD_MSB     = 11;
  localparam int unsigned IR_RD_LSB     = 7;
  localparam int unsigned IR_FUNCT3_MSB = 14;
  localparam int unsigned IR_FUNCT3_LSB = 12;
  localparam int unsigned IR_ALT_BIT    = 30;

  // Arithmetic op for OP / OP-IMM; alt (IR[30]) picks SUB only for register forms.
  function automatic logic [4:0] alu_arith_op(input logic [2:0] funct3,
                                               input logic       alt,
                                               input logic       is_reg);
    logic [4:0] op;
    case (funct3)
      3'b000:  op = (alt && is_reg) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/instruction_decoder_rv32i_imm_gen.sv
// Sign-extended immediate builder for each RV32I instruction format.
module instruction_decoder_rv32i_imm_gen
  import instruction_decoder_rv32i_pkg::*;
(
  input  logic [31:7] ir_i,
  input  logic [2:0]  fmt_i,
  output logic [31:0] imm_o
);

  always_comb begin
    case (fmt_i)
      FT_I:    imm_o = {{20{ir_i[31]}}, ir_i[31:20]};
      FT_S:    imm_o = {{20{ir_i[31]}}, ir_i[31:25], ir_i[11:7]};
      FT_B:    imm_o = {{19{ir_i[31]}}, ir_i[31], ir_i[7], ir_i[30:25], ir_i[11:8], 1'b0};
      FT_U:    imm_o = {ir_i[31:12], 12'b0};
      FT_J:    imm_o = {{11{ir_i[31]}}, ir_i[31], ir_i[19:12], ir_i[20], ir_i[30:21], 1'b0};
      default: imm_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/instruction_decoder_rv32i.sv
// Combinational RV32I instruction decoder with a sticky illegal-opcode flag.
module instruction_decoder_rv32i
  import instruction_decoder_rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        RST,
  input  logic [31:0] IR,
  output logic [4:0]  alu_instruction,
  output logic [31:0] immediate_value,
  output logic [2:0]  instruction_format_type,
  output logic [1:0]  write_back_type,
  output logic [1:0]  data_memory_read_status,
  output logic [1:0]  data_memory_write_status,
  output logic        data_memory_load_signed,
  output logic [4:0]  destination_register_number,
  output logic        pc_for_input_a,
  output logic        jump,
  output logic        illegal_seen
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       alt;
  logic       illegal_hit;
  logic       illegal_seen_d, illegal_seen_q;

  assign opcode = IR[IR_OPCODE_MSB:0];
  assign funct3 = IR[IR_FUNCT3_MSB:IR_FUNCT3_LSB];
  assign alt    = IR[IR_ALT_BIT];

  always_comb begin
    // NOTE: every output gets a NOP default first so no path through the case infers a latch.
    instruction_format_type  = FT_NONE;
    alu_instruction          = ALU_ADD;
    write_back_type          = WB_ALU;
    data_memory_read_status  = MEM_NONE;
    data_memory_write_status = MEM_NONE;
    data_memory_load_signed  = 1'b0;
    pc_for_input_a           = 1'b0;
    jump                     = 1'b0;
    illegal_hit              = 1'b0;
    case (opcode)
      OPC_OP: begin
        instruction_format_type = FT_R;
        alu_instruction         = alu_arith_op(funct3, alt, 1'b1);
      end
      OPC_OP_IMM: begin
        instruction_format_type = FT_I;
        alu_instruction         = alu_arith_op(funct3, alt, 1'b0);
      end
      OPC_LUI: begin
        instruction_format_type = FT_U;
        alu_instruction         = ALU_PASSB;
      end
      OPC_AUIPC: begin
        instruction_format_type = FT_U;
        pc_for_input_a          = 1'b1;
      end
      OPC_JAL: begin
        instruction_format_type = FT_J;
        jump                    = 1'b1;
        write_back_type         = WB_PC4;
      end
      OPC_JALR: begin
        instruction_format_type = FT_I;
        jump                    = 1'b1;
        write_back_type         = WB_PC4;
      end
      OPC_BRANCH: begin
        case (funct3)
          3'b000:  alu_instruction = ALU_EQ;
          3'b001:  alu_instruction = ALU_NE;
          3'b100:  alu_instruction = ALU_LT;
          3'b101:  alu_instruction = ALU_GE;
          3'b110:  alu_instruction = ALU_LTU;
          3'b111:  alu_instruction = ALU_GEU;
          default: illegal_hit     = 1'b1;
        endcase
        if (!illegal_hit) begin
          instruction_format_type = FT_B;
          jump                    = 1'b1;
        end
      end
      OPC_LOAD: begin
        // funct3[2] marks the unsigned variants; funct3[1:0] is the access size.
        if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) begin
          illegal_hit = 1'b1;
        end else begin
          instruction_format_type = FT_I;
          write_back_type         = WB_LOAD;
          data_memory_read_status = funct3[1:0] + 2'd1;
          data_memory_load_signed = ~funct3[2];
        end
      end
      OPC_STORE: begin
        if (funct3[2] || funct3[1:0] == 2'b11) begin
          illegal_hit = 1'b1;
        end else begin
          instruction_format_type  = FT_S;
          data_memory_write_status = funct3[1:0] + 2'd1;
        end
      end
      OPC_FENCE, OPC_SYSTEM: ;
      default: illegal_hit = 1'b1;
    endcase
  end

  always_comb begin
    case (instruction_format_type)
      FT_R, FT_I, FT_U, FT_J: destination_register_number = IR[IR_RD_MSB:IR_RD_LSB];
      default:                destination_register_number = 5'd0;
    endcase
  end

  instruction_decoder_rv32i_imm_gen u_imm_gen (
    .ir_i  (IR[31:7]),
    .fmt_i (instruction_format_type),
    .imm_o (immediate_value)
  );

  assign illegal_seen_d = illegal_seen_q | illegal_hit;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (RST) illegal_seen_q <= 1'b0;
    else     illegal_seen_q <= illegal_seen_d;
  end

  assign illegal_seen = illegal_seen_q;

endmodule

// File: tb/tb_instruction_decoder_rv32i.sv
// Scoreboard bench for the RV32I decoder: hand-encoded vectors and the sticky illegal flag.
module tb_instruction_decoder_rv32i;

  typedef struct packed {
    logic [4:0]  alu;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic [1:0]  wb;
    logic [1:0]  rd_st;
    logic [1:0]  wr_st;
    logic        sgn;
    logic [4:0]  rd;
    logic        pca;
    logic        jmp;
  } dec_t;

  localparam int NVEC = 19;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] IR  = 32'h0000_0013;
  logic [4:0]  alu_instruction;
  logic [31:0] immediate_value;
  logic [2:0]  instruction_format_type;
  logic [1:0]  write_back_type;
  logic [1:0]  data_memory_read_status;
  logic [1:0]  data_memory_write_status;
  logic        data_memory_load_signed;
  logic [4:0]  destination_register_number;
  logic        pc_for_input_a;
  logic        jump;
  logic        illegal_seen;

  int n_checks = 0;
  int n_errors = 0;

  dec_t        exp_q[$];
  dec_t        obs;
  logic [31:0] tbl_ir [NVEC];
  dec_t        tbl_exp[NVEC];

  instruction_decoder_rv32i dut (
    .clk                         (clk),
    .RST                         (RST),
    .IR                          (IR),
    .alu_instruction             (alu_instruction),
    .immediate_value             (immediate_value),
    .instruction_format_type     (instruction_format_type),
    .write_back_type             (write_back_type),
    .data_memory_read_status     (data_memory_read_status),
    .data_memory_write_status    (data_memory_write_status),
    .data_memory_load_signed     (data_memory_load_signed),
    .destination_register_number (destination_register_number),
    .pc_for_input_a              (pc_for_input_a),
    .jump                        (jump),
    .illegal_seen                (illegal_seen)
  );

  always #5 clk = ~clk;

  assign obs = {alu_instruction, immediate_value, instruction_format_type, write_back_type,
                data_memory_read_status, data_memory_write_status, data_memory_load_signed,
                destination_register_number, pc_for_input_a, jump};

  function automatic dec_t mk(input logic [4:0] alu, input logic [31:0] imm, input logic [2:0] fmt,
                              input logic [1:0] wb, input logic [1:0] rs, input logic [1:0] ws,
                              input logic sgn, input logic [4:0] rd, input logic pca,
                              input logic jmp);
    return '{alu: alu, imm: imm, fmt: fmt, wb: wb, rd_st: rs, wr_st: ws, sgn: sgn, rd: rd,
             pca: pca, jmp: jmp};
  endfunction

  task automatic load_table();
    //               IR              alu    imm            fmt wb  rs  ws  sg rd  pc jmp
    tbl_ir[0]  = 32'hFFD08293; tbl_exp[0]  = mk(5'h00, 32'hFFFFFFFD, 1, 0, 0, 0, 0, 5,  0, 0); // addi x5,x1,-3
    tbl_ir[1]  = 32'h402081B3; tbl_exp[1]  = mk(5'h01, 32'h00000000, 0, 0, 0, 0, 0, 3,  0, 0); // sub x3,x1,x2
    tbl_ir[2]  = 32'h4030D213; tbl_exp[2]  = mk(5'h12, 32'h00000403, 1, 0, 0, 0, 0, 4,  0, 0); // srai x4,x1,3
    tbl_ir[3]  = 32'h00C5F533; tbl_exp[3]  = mk(5'h02, 32'h00000000, 0, 0, 0, 0, 0, 10, 0, 0); // and x10,x11,x12
    tbl_ir[4]  = 32'h123452B7; tbl_exp[4]  = mk(5'h07, 32'h12345000, 4, 0, 0, 0, 0, 5,  0, 0); // lui
    tbl_ir[5]  = 32'h00001397; tbl_exp[5]  = mk(5'h00, 32'h00001000, 4, 0, 0, 0, 0, 7,  1, 0); // auipc x7,1
    tbl_ir[6]  = 32'h008000EF; tbl_exp[6]  = mk(5'h00, 32'h00000008, 5, 2, 0, 0, 0, 1,  0, 1); // jal x1,8
    tbl_ir[7]  = 32'hFFDFF06F; tbl_exp[7]  = mk(5'h00, 32'hFFFFFFFC, 5, 2, 0, 0, 0, 0,  0, 1); // jal x0,-4
    tbl_ir[8]  = 32'h000280E7; tbl_exp[8]  = mk(5'h00, 32'h00000000, 1, 2, 0, 0, 0, 1,  0, 1); // jalr x1,0(x5)
    tbl_ir[9]  = 32'hFE208EE3; tbl_exp[9]  = mk(5'h08, 32'hFFFFFFFC, 3, 0, 0, 0, 0, 0,  0, 1); // beq -4
    tbl_ir[10] = 32'h0020F863; tbl_exp[10] = mk(5'h0D, 32'h00000010, 3, 0, 0, 0, 0, 0,  0, 1); // bgeu +16
    tbl_ir[11] = 32'h00104183; tbl_exp[11] = mk(5'h00, 32'h00000001, 1, 1, 1, 0, 0, 3,  0, 0); // lbu x3,1(x0)
    tbl_ir[12] = 32'hFFE11303; tbl_exp[12] = mk(5'h00, 32'hFFFFFFFE, 1, 1, 2, 0, 1, 6,  0, 0); // lh x6,-2(x2)
    tbl_ir[13] = 32'h0020A423; tbl_exp[13] = mk(5'h00, 32'h00000008, 2, 0, 0, 3, 0, 0,  0, 0); // sw x2,8(x1)
    tbl_ir[14] = 32'hFE208FA3; tbl_exp[14] = mk(5'h00, 32'hFFFFFFFF, 2, 0, 0, 1, 0, 0,  0, 0); // sb x2,-1(x1)
    tbl_ir[15] = 32'h0000000F; tbl_exp[15] = mk(5'h00, 32'h00000000, 7, 0, 0, 0, 0, 0,  0, 0); // fence
    tbl_ir[16] = 32'h00000073; tbl_exp[16] = mk(5'h00, 32'h00000000, 7, 0, 0, 0, 0, 0,  0, 0); // ecall
    tbl_ir[17] = 32'hFFFFFFFF; tbl_exp[17] = mk(5'h00, 32'h00000000, 7, 0, 0, 0, 0, 0,  0, 0); // bad opcode
    tbl_ir[18] = 32'h0000B183; tbl_exp[18] = mk(5'h00, 32'h00000000, 7, 0, 0, 0, 0, 0,  0, 0); // load funct3 011
  endtask

  // Drive one instruction just after the rising edge and queue its expected decode.
  task automatic push_vec(input int idx);
    @(posedge clk);
    #1;
    IR = tbl_ir[idx];
    exp_q.push_back(tbl_exp[idx]);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    IR  = 32'hFFFFFFFF;
    repeat (2) @(posedge clk);
    #1;
    RST = 1'b0;
    IR  = tbl_ir[0];
    @(negedge clk);
    n_checks++;
    if (illegal_seen !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_illegal_seen: got %b expected 0", illegal_seen);
    end
  endtask

  task automatic test_range(input string name, input int lo, input int hi);
    dec_t exp;
    for (int i = lo; i <= hi; i++) begin
      push_vec(i);
      @(negedge clk);
      exp = exp_q.pop_front();
      n_checks++;
      if (obs !== exp) begin
        n_errors++;
        $display("FAIL %s[%0d] IR=%h: got %h expected %h", name, i, tbl_ir[i], obs, exp);
      end
    end
  endtask

  task automatic test_legal_keeps_flag_clear();
    test_range("legal_nop", 15, 16);
    @(posedge clk);
    #1;
    n_checks++;
    if (illegal_seen !== 1'b0) begin
      n_errors++;
      $display("FAIL legal_flag_clear: got %b expected 0", illegal_seen);
    end
  endtask

  task automatic test_illegal_flag();
    RST = 1'b1;
    @(posedge clk);
    #1;
    RST = 1'b0;
    IR  = 32'hFFFFFFFF;
    @(negedge clk);
    n_checks++;
    if (illegal_seen !== 1'b0) begin
      n_errors++;
      $display("FAIL illegal_before_edge: got %b expected 0", illegal_seen);
    end
    @(posedge clk);
    #1;
    IR = tbl_ir[0];
    n_checks++;
    if (illegal_seen !== 1'b1) begin
      n_errors++;
      $display("FAIL illegal_set: got %b expected 1", illegal_seen);
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (illegal_seen !== 1'b1) begin
      n_errors++;
      $display("FAIL illegal_sticky: got %b expected 1", illegal_seen);
    end
    IR  = 32'hFFFFFFFF;
    RST = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (illegal_seen !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_priority: got %b expected 0", illegal_seen);
    end
    RST = 1'b0;
    IR  = tbl_ir[11];
    @(posedge clk);
    #1;
    n_checks++;
    if (illegal_seen !== 1'b0) begin
      n_errors++;
      $display("FAIL after_reset_clear: got %b expected 0", illegal_seen);
    end
  endtask

  task automatic test_back_to_back();
    dec_t exp;
    int   idx;
    for (int n = 0; n < 24; n++) begin
      idx = int'($urandom_range(0, 16));
      push_vec(idx);
      @(negedge clk);
      exp = exp_q.pop_front();
      n_checks++;
      if (obs !== exp) begin
        n_errors++;
        $display("FAIL b2b[%0d] IR=%h: got %h expected %h", n, tbl_ir[idx], obs, exp);
      end
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (illegal_seen !== 1'b0 || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL b2b_end: illegal_seen %b pending %0d expected 0 and 0", illegal_seen,
               exp_q.size());
    end
  endtask

  initial begin
    load_table();
    test_reset();
    test_range("alu", 0, 3);
    test_range("upper_jump", 4, 8);
    test_range("branch", 9, 10);
    test_range("mem", 11, 14);
    test_legal_keeps_flag_clear();
    test_range("illegal_decode", 17, 18);
    test_illegal_flag();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
